// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-addressable RV32I load/store data memory with alignment, range and funct3 fault detection
module mem_ctrl #(
  parameter int          DEPTH     = 16384,
  parameter bit          READ_SYNC = 1'b1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_word;
  logic [1:0]    r_lane;
  logic [2:0]    r_f3;
  logic          r_rvalid;
  logic          r_err;
  logic [29:0]   w_word;
  logic [AW-1:0] w_idx;
  logic          w_range;
  logic          w_align;
  logic          w_f3_bad;
  logic          w_fault;
  logic          w_st;
  logic          w_ld;
  logic          w_ld_ok;
  logic          w_live;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [31:0]   w_rd;

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] l, input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {l, 3'b000});
    h = l[1] ? w[31:16] : w[15:0];
    return f[1:0] == 2'b00 ? {{24{b[7] & ~f[2]}}, b} :
           f[1:0] == 2'b01 ? {{16{h[15] & ~f[2]}}, h} : w;
  endfunction

  assign w_word   = 30'((addr - BASE_ADDR) >> 2);
  assign w_idx    = w_word[AW-1:0];
  assign w_range  = (addr < BASE_ADDR) || ({2'b00, w_word} >= 32'(DEPTH));
  assign w_align  = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign w_f3_bad = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (we && funct3[2]);
  assign w_fault  = w_range || w_align || w_f3_bad;
  assign w_st     = req && we && !w_fault;
  assign w_ld     = req && !we;
  assign w_ld_ok  = w_ld && !w_fault;
  assign w_rd     = r_mem[w_idx];

  // byte enables and lane-replicated store data from width and byte offset
  always_comb begin
    w_be = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
           funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_wd = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
           funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  end

  // lane writes into the array; storage itself is never cleared, writes are blocked while rst is high
  always_ff @(posedge clk or posedge rst)
    if (!rst)
      for (int i = 0; i < 4; i++)
        if (w_st && w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];

  // capture access outcome and keep the last legal load word with its lane and width
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_word   <= 32'h0;
      r_lane   <= 2'b00;
      r_f3     <= 3'b000;
    end else begin
      r_rvalid <= READ_SYNC && w_ld_ok;
      r_err    <= req && w_fault && (READ_SYNC || we);
      if (w_ld_ok) begin
        r_word <= w_rd;
        r_lane <= addr[1:0];
        r_f3   <= funct3;
      end
    end

  // present registered or live load result; faults force rdata to zero
  always_comb begin
    w_live = !READ_SYNC && w_ld && !rst;
    rvalid = READ_SYNC ? r_rvalid : w_live && !w_fault;
    err    = READ_SYNC ? r_err : (w_live && w_fault) || r_err;
    rdata  = err ? 32'h0 : (!READ_SYNC && rvalid) ? ext(w_rd, addr[1:0], funct3) : ext(r_word, r_lane, r_f3);
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 16384: number of 32-bit words in the data memory; power of two, 2..65536.
REQ-002 Parameter READ_SYNC, default 1: 1 = registered read (1-cycle load latency); 0 = combinational read (0-cycle latency).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; word-aligned.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst  input  1: reset, asynchronous and active-high.
REQ-006 Port req  input  1: access request valid this cycle.
REQ-007 Port we  input  1: 1 = store, 0 = load; sampled only when req=1.
REQ-008 Port funct3  input  3: RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-009 Port addr  input  32: byte address.
REQ-010 Port wdata  input  32: store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 Port rdata  output  32: load result, extended per funct3.
REQ-012 Port rvalid  output  1: rdata valid for the completing load.
REQ-013 Port err  output  1: completing access faulted (misaligned, out of range, or illegal funct3).

Function
REQ-014 Word index = (addr - BASE_ADDR) >> 2; byte lane = addr[1:0].
REQ-015 One request accepted per cycle; no stall, no backpressure.
REQ-016 Fault conditions: word index >= DEPTH or addr < BASE_ADDR; h/hu with addr[0]=1; w with addr[1:0]!=0; funct3 in {011,110,111}; funct3 10x with we=1.
REQ-017 Faulting store: no memory lane written; err=1 one cycle after request (both READ_SYNC values).
REQ-018 Faulting load: rvalid=0, rdata=0, err=1 with the same latency as a legal load.
REQ-019 Legal store: byte-enable lanes written at the rising edge of the request cycle; sb writes lane addr[1:0] with wdata[7:0]; sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; sw writes all four lanes.
REQ-020 Unwritten lanes of a store word are unchanged; no read-modify-write cycle.
REQ-021 Legal load, READ_SYNC=1: rvalid=1 and rdata exactly one cycle after req; READ_SYNC=0: same cycle, combinational from addr.
REQ-022 Load extension: b/h sign-extend from bit 7/15 of the selected lane(s); bu/hu zero-extend; w passes the word.
REQ-023 Lane select and extension (READ_SYNC=1) use addr[1:0] and funct3 registered with the request, not live inputs.
REQ-024 Store at cycle N then load to same word at cycle N+1 returns the post-store value.
REQ-025 Cycles with req=0, or after a store (READ_SYNC=1): rvalid=0, err=0 next cycle; rdata holds last valid load value.
REQ-026 Back-to-back loads: one rvalid per load, in order, no bubbles.
REQ-027 Memory array has no reset; initial contents undefined except via optional init file.

Reset
REQ-028 rst=1: rvalid=0, err=0, rdata=0, registered lane/funct3 cleared, immediately (asynchronous).
REQ-029 Load in flight when rst asserts is dropped: no rvalid after rst deasserts.
REQ-030 Store in the same cycle as rst=1 does not write memory; memory contents otherwise preserved across reset.
REQ-031 First request accepted on the first rising edge with rst=0.

Verification
REQ-032 sw 0x8000_00FF @0x10, then lb @0x10 -> rdata=0xFFFF_FFFF, rvalid=1 one cycle later; lbu @0x10 -> 0x0000_00FF; lw @0x10 -> 0x8000_00FF.
REQ-033 sw 0x1122_3344 @0x20, sb 0xAA @0x22, sh 0xBEEF @0x20, lw @0x20 -> 0x11AA_BEEF.
REQ-034 lh @0x21 -> err=1, rvalid=0, rdata=0; sw 0x1 @0x22 -> err=1, following lw @0x20 unchanged.
REQ-035 DEPTH=16, lw @0x40 -> err=1; lw @0x3C -> legal load, rvalid=1.
REQ-036 Back-to-back lw @0x0,0x4,0x8 on three consecutive cycles -> three consecutive rvalid pulses, data in order.
REQ-037 lw issued, rst pulsed asynchronously mid-cycle -> rvalid/err/rdata=0 at once, no rvalid after release; prior memory data still readable.
